hilo_muldiv_unit: RTL and testbench

- EX-stage multi-cycle HI/LO unit, directly downstream of the ID/EX pipeline register.
- Consumes the ID/EX HI/LO control decode (as a 3-bit op), ReadData1Out and ReadData2Out.
- Executes iterative multiply/divide, multiply-accumulate/subtract and MTHI/MTLO into architectural HI/LO.
- Exposes HI/LO to the EX result mux and asserts Stall back to the IF/ID/ID-EX stages while a result is pending.

---
 rtl/hilo_muldiv_unit_pkg.sv | 45 ++++
 rtl/hilo_sign_fixup.sv | 68 ++++++
 rtl/hilo_muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit_pkg
// Shared definitions for the EX-stage HI/LO unit: the 3-bit HI/LO op
// encoding (also decoded by the ID-stage controller), the FSM state
// encoding and small op-classification helpers.
// ---------------------------------------------------------------------------
package hilo_muldiv_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } state_t;

  // Ops whose operands are two's complement and need magnitude conversion.
  function automatic logic is_signed_op(input logic [2:0] op);
    logic res;
    case (op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: res = 1'b1;
      default:                           res = 1'b0;
    endcase
    return res;
  endfunction

  // Ops that run the restoring divider instead of the shift-add multiplier.
  function automatic logic is_div_op(input logic [2:0] op);
    logic res;
    case (op)
      OP_DIV, OP_DIVU: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hilo_sign_fixup.sv
// ---------------------------------------------------------------------------
// hilo_sign_fixup
// Combinational final stage of an iterative HI/LO op. Applies the result
// signs to the unsigned magnitudes produced by the iterative core and forms
// the new {HI,LO} value, including the MADD/MSUB accumulate.
//   op          : HI/LO op being completed
//   prod_mag    : unsigned 2*WIDTH product magnitude
//   quot_mag    : unsigned quotient magnitude
//   rem_mag     : unsigned remainder magnitude
//   neg_result  : operand signs differed (negate product / quotient)
//   neg_rem     : dividend was negative (negate remainder)
//   div_zero    : divisor was zero
//   raw_a       : dividend as presented (HI on divide-by-zero)
//   hi_in/lo_in : current architectural HI/LO (accumulate source)
//   hi_out/lo_out : value to write into HI/LO
// ---------------------------------------------------------------------------
module hilo_sign_fixup
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [2*WIDTH-1:0] prod_mag,
  input  logic [WIDTH-1:0]   quot_mag,
  input  logic [WIDTH-1:0]   rem_mag,
  input  logic               neg_result,
  input  logic               neg_rem,
  input  logic               div_zero,
  input  logic [WIDTH-1:0]   raw_a,
  input  logic [WIDTH-1:0]   hi_in,
  input  logic [WIDTH-1:0]   lo_in,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] acc_s;
  logic [2*WIDTH-1:0] res_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;

  // Signed results and the selected {HI,LO} update; all arithmetic wraps.
  always_comb begin
    prod_s = neg_result ? ({(2*WIDTH){1'b0}} - prod_mag) : prod_mag;
    quot_s = neg_result ? ({WIDTH{1'b0}} - quot_mag) : quot_mag;
    rem_s  = neg_rem ? ({WIDTH{1'b0}} - rem_mag) : rem_mag;
    acc_s  = {hi_in, lo_in};
    res_s  = acc_s;
    case (op)
      OP_MULT, OP_MULTU: res_s = prod_s;
      OP_MADD:           res_s = acc_s + prod_s;
      OP_MSUB:           res_s = acc_s - prod_s;
      OP_DIV, OP_DIVU: begin
        // Divide-by-zero reports the raw dividend and an all-ones quotient
        // regardless of signedness, so bypass the sign correction.
        if (div_zero) begin
          res_s = {raw_a, {WIDTH{1'b1}}};
        end else begin
          res_s = {rem_s, quot_s};
        end
      end
      default:           res_s = acc_s;
    endcase
    hi_out = res_s[2*WIDTH-1:WIDTH];
    lo_out = res_s[WIDTH-1:0];
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
// EX-stage multi-cycle HI/LO unit: iterative multiply (radix-2 shift-add),
// restoring divide, MADD/MSUB and single-cycle MTHI/MTLO. Holds the
// architectural HI/LO registers and stalls upstream while a result pends.
//   Clk, RstN     : clock, asynchronous active-low reset
//   StartIn/OpIn  : HI/LO op valid in EX and its encoding
//   OperandA/B    : rs / rt values
//   HiLoReadIn    : MFHI/MFLO in EX this cycle
//   Busy          : iterative op in flight
//   Stall         : freeze IF/ID/ID-EX (Busy & (StartIn | HiLoReadIn))
//   DonePulse     : one cycle after HI/LO written by an iterative op
//   HiOut/LoOut   : architectural HI/LO
// ---------------------------------------------------------------------------
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             StartIn,
  input  logic [2:0]       OpIn,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiLoReadIn,
  output logic             Busy,
  output logic             Stall,
  output logic             DonePulse,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           op_r;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_r;
  // Multiplicand (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]     mcand_r;
  logic                 neg_result_r;
  logic                 neg_rem_r;
  logic                 div_zero_r;
  logic [WIDTH-1:0]     raw_a_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 a_neg_s;
  logic                 b_neg_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [WIDTH-1:0]     fix_hi_s;
  logic [WIDTH-1:0]     fix_lo_s;

  // Operand magnitudes and sign flags for the op being presented.
  always_comb begin
    a_neg_s = is_signed_op(OpIn) & OperandA[WIDTH-1];
    b_neg_s = is_signed_op(OpIn) & OperandB[WIDTH-1];
    a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - OperandA) : OperandA;
    b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - OperandB) : OperandB;
  end

  // One iteration of shift-add multiply and of restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mcand_r};
    // A borrow out of the trial subtraction means the quotient bit is 0
    // and the shifted remainder is kept.
    if (div_diff_s[WIDTH]) begin
      div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end

  hilo_sign_fixup #(
    .WIDTH (WIDTH)
  ) u_fixup (
    .op         (op_r),
    .prod_mag   (acc_r),
    .quot_mag   (acc_r[WIDTH-1:0]),
    .rem_mag    (acc_r[2*WIDTH-1:WIDTH]),
    .neg_result (neg_result_r),
    .neg_rem    (neg_rem_r),
    .div_zero   (div_zero_r),
    .raw_a      (raw_a_r),
    .hi_in      (hi_r),
    .lo_in      (lo_r),
    .hi_out     (fix_hi_s),
    .lo_out     (fix_lo_s)
  );

  // Control FSM, iteration counter, datapath shift registers and HI/LO.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      op_r         <= OP_MULT;
      acc_r        <= {(2*WIDTH){1'b0}};
      mcand_r      <= {WIDTH{1'b0}};
      neg_result_r <= 1'b0;
      neg_rem_r    <= 1'b0;
      div_zero_r   <= 1'b0;
      raw_a_r      <= {WIDTH{1'b0}};
      hi_r         <= {WIDTH{1'b0}};
      lo_r         <= {WIDTH{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (StartIn) begin
            case (OpIn)
              OP_MTHI: hi_r <= OperandA;
              OP_MTLO: lo_r <= OperandA;
              default: begin
                op_r         <= OpIn;
                cnt_r        <= {CNT_W{1'b0}};
                neg_result_r <= a_neg_s ^ b_neg_s;
                neg_rem_r    <= a_neg_s;
                div_zero_r   <= (OperandB == {WIDTH{1'b0}});
                raw_a_r      <= OperandA;
                busy_r       <= 1'b1;
                if (is_div_op(OpIn)) begin
                  acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                  mcand_r <= b_mag_s;
                  state_r <= DIV;
                end else begin
                  acc_r   <= {{WIDTH{1'b0}}, b_mag_s};
                  mcand_r <= a_mag_s;
                  state_r <= MUL;
                end
              end
            endcase
          end
        end
        MUL: begin
          acc_r <= mul_next_s;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIXUP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DIV: begin
          acc_r <= div_next_s;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIXUP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FIXUP: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign Busy      = busy_r;
  assign DonePulse = done_r;
  assign HiOut     = hi_r;
  assign LoOut     = lo_r;
  // Stall is combinational so the instruction in EX is held the same cycle.
  assign Stall     = busy_r & (StartIn | HiLoReadIn);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          RstN;
  logic          StartIn = 1'b0;
  logic [2:0]    OpIn = 3'd0;
  logic [W-1:0]  OperandA = '0;
  logic [W-1:0]  OperandB = '0;
  logic          HiLoReadIn = 1'b0;
  logic          Busy, Stall, DonePulse;
  logic [W-1:0]  HiOut, LoOut;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;

  // behavioural model state
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;
  logic [63:0]   m_pend = '0;
  int            m_left = 0;
  logic          m_done = 1'b0;
  logic          m_acc = 1'b0;

  hilo_muldiv_unit dut (
    .Clk        (Clk),
    .RstN       (RstN),
    .StartIn    (StartIn),
    .OpIn       (OpIn),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .HiLoReadIn (HiLoReadIn),
    .Busy       (Busy),
    .Stall      (Stall),
    .DonePulse  (DonePulse),
    .HiOut      (HiOut),
    .LoOut      (LoOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural result of a HI/LO op, returned as {HI,LO}.
  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [63:0] hl);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = sa * sb;
    case (op)
      3'd0: return p;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return hl + p;
      3'd5: return hl - p;
      default: return hl;
    endcase
  endfunction

  // Model: an accepted iterative op completes WIDTH+1 cycles later.
  always @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0; m_acc = 1'b0;
    end else begin
      m_done = 1'b0;
      m_acc  = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (StartIn) begin
        m_acc = 1'b1;
        if (OpIn == 3'd6) m_hi = OperandA;
        else if (OpIn == 3'd7) m_lo = OperandA;
        else begin
          m_pend = model_result(OpIn, OperandA, OperandB, {m_hi, m_lo});
          m_left = W + 1;
        end
      end
    end
  end

  // Compare process: every cycle, just after the active edge.
  always @(posedge Clk) begin
    #1;
    chk("busy", {63'h0, Busy}, {63'h0, m_left > 0});
    chk("done", {63'h0, DonePulse}, {63'h0, m_done});
    chk("stall", {63'h0, Stall}, {63'h0, (m_left > 0) && (StartIn || HiLoReadIn)});
    chk("hi", {32'h0, HiOut}, {32'h0, m_hi});
    chk("lo", {32'h0, LoOut}, {32'h0, m_lo});
    if (Busy) busy_cnt++;
    if (DonePulse) done_cnt++;
    if (Stall) stall_cnt++;
  end

  // Present an op (called at a negedge) and hold it until accepted.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    StartIn = 1'b1; OpIn = op; OperandA = a; OperandB = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (m_acc) begin
        StartIn = 1'b0;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", op);
    StartIn = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (m_left == 0) return;
      @(negedge Clk);
    end
    n_checks++; n_fail++;
    $display("FAIL idle_timeout: still busy after 200 cycles");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RstN = 1'b1;
    #1 RstN = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_hi", {32'h0, HiOut}, 64'h0);
    chk("reset_busy", {63'h0, Busy}, 64'h0);
    RstN = 1'b1;
    @(negedge Clk);

    // MULT -3 * 5
    busy_cnt = 0; done_cnt = 0;
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle();
    @(negedge Clk);
    chk("mult_hl", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("mult_done_pulses", 64'(done_cnt), 64'd1);

    issue(3'd3, 32'd100, 32'd7); wait_idle();
    chk("divu_hl", {HiOut, LoOut}, {32'd2, 32'd14});
    issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_idle();
    chk("div_neg_hl", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd2, 32'h1234_5678, 32'd0); wait_idle();
    chk("div_zero_hl", {HiOut, LoOut}, 64'h1234_5678_FFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    chk("div_ovf_hl", {HiOut, LoOut}, 64'h0000_0000_8000_0000);

    // accumulate
    issue(3'd7, 32'hFFFF_FFFF, 32'd0);
    issue(3'd6, 32'd0, 32'd0);
    chk("mtlo_mthi_hl", {HiOut, LoOut}, 64'h0000_0000_FFFF_FFFF);
    issue(3'd4, 32'd2, 32'd3); wait_idle();
    chk("madd_hl", {HiOut, LoOut}, 64'h0000_0001_0000_0005);
    issue(3'd5, 32'd2, 32'd3); wait_idle();
    chk("msub_hl", {HiOut, LoOut}, 64'h0000_0000_FFFF_FFFF);

    // MULTU, then MFHI + MTHI presented while busy
    issue(3'd1, 32'h0001_0000, 32'h0003_0003);
    repeat (4) @(negedge Clk);
    stall_cnt = 0;
    HiLoReadIn = 1'b1;
    issue(3'd6, 32'h0000_ABCD, 32'd0);
    HiLoReadIn = 1'b0;
    chk("stall_cycles", 64'(stall_cnt), 64'd28);
    chk("mthi_after_busy", {HiOut, LoOut}, 64'h0000_ABCD_0003_0000);

    // asynchronous reset in the middle of a DIVU
    issue(3'd3, 32'hDEAD_BEEF, 32'd3);
    repeat (10) @(posedge Clk);
    #2 RstN = 1'b0;
    #1;
    chk("arst_hl", {HiOut, LoOut}, 64'h0);
    chk("arst_busy", {63'h0, Busy}, 64'h0);
    #1 RstN = 1'b1;
    @(negedge Clk);
    issue(3'd0, 32'd6, 32'd7); wait_idle();
    chk("mult_after_rst", {HiOut, LoOut}, 64'd42);

    // randomized ops, sometimes back-to-back so StartIn is held off by Busy
    for (int n = 0; n < 40; n++) begin
      HiLoReadIn = 1'($urandom_range(0, 1));
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    HiLoReadIn = 1'b0;
    wait_idle();
    repeat (2) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
